// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared slot type, scheduler states and register-read helper
package sched_pkg;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        uses_rs1;
      logic        uses_rs2;
      logic        writes_rd;
      logic        is_mem;
      logic        is_load;
      logic        is_ctrl;
   } slot_info_t;

   typedef enum logic {
      NORMAL = 1'b0,
      HOLD   = 1'b1
   } sched_state_t;

   localparam slot_info_t SLOT_NONE = '0;

   function automatic logic reads_reg(slot_info_t s, logic [4:0] r);
      return (s.uses_rs1 && (s.rs1 == r)) || (s.uses_rs2 && (s.rs2 == r));
   endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// rtl/issue_hazard_check.sv - RAW/WAW check of one producer against one consumer slot
module issue_hazard_check
   import sched_pkg::*;
(
   input  logic       prod_writes,
   input  logic [4:0] prod_rd,
   input  slot_info_t cons,
   output logic       raw,
   output logic       waw
);

   // x0 is hardwired, so a write to it never creates a dependency
   logic prod_live;

   assign prod_live = prod_writes & (prod_rd != 5'd0);
   assign raw       = prod_live & reads_reg(cons, prod_rd);
   assign waw       = prod_live & cons.writes_rd & (cons.rd == prod_rd);

endmodule

// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - two-pipe issue controller with packet split, hold and load-use stall
module dual_issue_scheduler
   import sched_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pkt_valid,
   input  slot_info_t       pkt_slot0,
   input  slot_info_t       pkt_slot1,
   output logic             pkt_ready,
   input  logic             dx_load_valid,
   input  logic [4:0]       dx_load_rd,
   input  logic             flush,
   output logic             issue_a_valid,
   output slot_info_t       issue_a,
   output logic             issue_b_valid,
   output slot_info_t       issue_b,
   output logic             holding,
   output logic [CNT_W-1:0] cnt_dual,
   output logic [CNT_W-1:0] cnt_single,
   output logic [CNT_W-1:0] cnt_stall
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   sched_state_t state, state_nxt;
   slot_info_t   hold_q, hold_nxt;
   slot_info_t   single_slot;
   logic         single_go;
   logic         inc_dual, inc_single, inc_stall;
   logic         raw01, waw01, lu0, lu1, luh;
   logic         unused_lu0_waw, unused_lu1_waw, unused_luh_waw;
   logic         pair_ok;

   issue_hazard_check u_pair (
      .prod_writes (pkt_slot0.writes_rd),
      .prod_rd     (pkt_slot0.rd),
      .cons        (pkt_slot1),
      .raw         (raw01),
      .waw         (waw01)
   );

   issue_hazard_check u_lu0 (
      .prod_writes (dx_load_valid),
      .prod_rd     (dx_load_rd),
      .cons        (pkt_slot0),
      .raw         (lu0),
      .waw         (unused_lu0_waw)
   );

   issue_hazard_check u_lu1 (
      .prod_writes (dx_load_valid),
      .prod_rd     (dx_load_rd),
      .cons        (pkt_slot1),
      .raw         (lu1),
      .waw         (unused_lu1_waw)
   );

   issue_hazard_check u_luh (
      .prod_writes (dx_load_valid),
      .prod_rd     (dx_load_rd),
      .cons        (hold_q),
      .raw         (luh),
      .waw         (unused_luh_waw)
   );

   assign pair_ok = pkt_slot1.valid & ~pkt_slot0.is_mem & ~pkt_slot0.is_ctrl &
                    ~pkt_slot1.is_ctrl & ~raw01 & ~waw01 & ~lu1;

   assign holding = (state == HOLD);

   always_comb begin
      state_nxt     = state;
      hold_nxt      = hold_q;
      pkt_ready     = 1'b0;
      issue_a_valid = 1'b0;
      issue_a       = SLOT_NONE;
      issue_b_valid = 1'b0;
      issue_b       = SLOT_NONE;
      single_slot   = SLOT_NONE;
      single_go     = 1'b0;
      inc_dual      = 1'b0;
      inc_single    = 1'b0;
      inc_stall     = 1'b0;
      if (!reset) begin
         state_nxt = NORMAL;
      end else if (flush) begin
         state_nxt = NORMAL;
         hold_nxt  = SLOT_NONE;
      end else begin
         case (state)
            NORMAL: begin
               if (pkt_valid) begin
                  if (lu0) begin
                     inc_stall = 1'b1;
                  end else if (pair_ok) begin
                     issue_a_valid = 1'b1;
                     issue_a       = pkt_slot0;
                     issue_b_valid = 1'b1;
                     issue_b       = pkt_slot1;
                     pkt_ready     = 1'b1;
                     inc_dual      = 1'b1;
                  end else begin
                     single_slot = pkt_slot0;
                     single_go   = 1'b1;
                     pkt_ready   = 1'b1;
                     if (pkt_slot1.valid) begin
                        hold_nxt  = pkt_slot1;
                        state_nxt = HOLD;
                     end
                  end
               end
            end
            HOLD: begin
               if (luh) begin
                  inc_stall = 1'b1;
               end else begin
                  single_slot = hold_q;
                  single_go   = 1'b1;
                  hold_nxt    = SLOT_NONE;
                  state_nxt   = NORMAL;
               end
            end
            default: state_nxt = NORMAL;
         endcase
      end
      // a lone instruction goes to B only when it needs the memory port
      if (single_go) begin
         inc_single = 1'b1;
         if (single_slot.is_mem) begin
            issue_b_valid = 1'b1;
            issue_b       = single_slot;
         end else begin
            issue_a_valid = 1'b1;
            issue_a       = single_slot;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= NORMAL;
         hold_q     <= SLOT_NONE;
         cnt_dual   <= '0;
         cnt_single <= '0;
         cnt_stall  <= '0;
      end else begin
         state  <= state_nxt;
         hold_q <= hold_nxt;
         if (inc_dual)   cnt_dual   <= cnt_dual + CNT_ONE;
         if (inc_single) cnt_single <= cnt_single + CNT_ONE;
         if (inc_stall)  cnt_stall  <= cnt_stall + CNT_ONE;
      end
   end

endmodule
